ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameters (name, default, meaning): DATA_W, 8, RAM data width; ADDR_W, 4, RAM address width.
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, sole clock, rising edge.
- rst_n, in, 1, synchronous active-low reset.
- req_a, in, 1, requester A access request.
- wr_a, in, 1, A write (1) / read (0).
- addr_a, in, ADDR_W, A address.
- wdata_a, in, DATA_W, A write data.
- gnt_a, out, 1, A command issued.
- rdata_a, out, DATA_W, A read data.
- rvalid_a, out, 1, A read data valid.
- req_b, wr_b, addr_b, wdata_b, gnt_b, rdata_b, rvalid_b: same as the A ports, for requester B.
- ram_en, out, 1, RAM enable.
- ram_wr, out, 1, RAM write.
- ram_addr, out, ADDR_W, RAM address.
- ram_wdata, out, DATA_W, RAM write data.
- ram_rdata, in, DATA_W, RAM read data, valid one cycle after a read command.
- busy, out, 1, high whenever the FSM is not in IDLE.
REQ-003 All outputs SHALL be registered; no tristate on any port.

Function
REQ-004 The FSM SHALL have three states: IDLE, ACCESS and RESP.
REQ-005 IDLE: if req_a or req_b is high, the block SHALL select a winner, latch that requester's wr/addr/wdata and enter ACCESS; otherwise it SHALL stay in IDLE.
REQ-006 ACCESS lasts exactly 1 cycle: ram_en=1, ram_wr/ram_addr/ram_wdata are driven from the latched command, and the winner's gnt is 1.
REQ-007 From ACCESS the FSM SHALL go to IDLE on a write and to RESP on a read.
REQ-008 RESP lasts 1 cycle: ram_en=0; the block SHALL capture ram_rdata into the winner's rdata at the end of the cycle.
REQ-009 The winner's rvalid SHALL pulse for exactly 1 cycle, in the cycle after RESP.
REQ-010 The winner's rdata SHALL hold its value until that requester's next read completes.
REQ-011 Latency from the edge that samples req: ACCESS is the next cycle; rvalid comes 3 cycles after that edge.
REQ-012 Throughput: one write per 2 cycles; one read per 3 cycles.
REQ-013 Handshake: a requester SHALL hold req and its command stable until it samples gnt=1, and SHALL drop req at that same edge unless it has a new command.
REQ-014 Arbitration is round-robin on a last_grant register:
- Single request: that requester wins.
- Both requesting: the requester not granted last wins.
REQ-015 last_grant SHALL update only in ACCESS.
REQ-016 gnt_a and gnt_b SHALL never be high in the same cycle; only one command is outstanding at a time.
REQ-017 A req that rises during ACCESS or RESP SHALL wait and be arbitrated in the next IDLE cycle.
REQ-018 A req that drops while the FSM is in IDLE before being sampled SHALL cause no access.
REQ-019 ram_wr, ram_addr and ram_wdata SHALL be 0 whenever ram_en=0.
REQ-020 Address and data SHALL pass through unmodified; there is no arithmetic on them and no wrap-around handling beyond ADDR_W.

Reset
REQ-021 When rst_n=0 at a rising edge: FSM to IDLE; all gnt, rvalid, ram_en, ram_wr and busy to 0; ram_addr, ram_wdata, rdata_a and rdata_b to 0; last_grant to B, so A wins the first tie.
REQ-022 A reset during ACCESS or RESP SHALL abort the operation: no rvalid for it and no further RAM command.
REQ-023 Reset SHALL take priority over every other event in the same cycle.

Configuration
REQ-024 The macro is FIXED_PRIORITY_EN.
- Defined: A always wins ties; last_grant is unused and B can starve.
- Undefined (default): round-robin per REQ-014.
- All other behaviour is identical in both builds.

Verification
REQ-025 Write A addr 4'h1 data 8'hFF -> gnt_a and ram_en=1, ram_wr=1, ram_addr=4'h1, ram_wdata=8'hFF in the same cycle; busy for 1 cycle only.
REQ-026 Read A addr 4'h1 with the RAM model returning 8'hFF -> rvalid_a pulses 3 cycles after req is sampled with rdata_a=8'hFF; rvalid_b stays 0.
REQ-027 req_a and req_b held continuously, both writing -> grants A,B,A,B; gnt spacing is 2 cycles; with FIXED_PRIORITY_EN, A,A,A.
REQ-028 Read B addr 4'h3 with reset pulsed in RESP -> no rvalid_b, all outputs 0 next cycle, then A wins a following tie.
REQ-029 req_b rises during A's ACCESS -> B granted in the first cycle after the next IDLE; no overlapping gnt.
REQ-030 No requests for 20 cycles -> ram_en, busy and both gnt stay 0.

Source files
------------

// File: rtl/ram_arbiter_if.sv
// Bus bundle for ram_arbiter: two requester ports (A and B) and the
// single-port RAM command/response path.
// master: the requesters plus the RAM (drives requests and ram_rdata).
// slave:  the arbiter itself.
interface ram_arbiter_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    // Requester A
    logic              req_a;
    logic              wr_a;
    logic [ADDR_W-1:0] addr_a;
    logic [DATA_W-1:0] wdata_a;
    logic              gnt_a;
    logic [DATA_W-1:0] rdata_a;
    logic              rvalid_a;

    // Requester B
    logic              req_b;
    logic              wr_b;
    logic [ADDR_W-1:0] addr_b;
    logic [DATA_W-1:0] wdata_b;
    logic              gnt_b;
    logic [DATA_W-1:0] rdata_b;
    logic              rvalid_b;

    // RAM side
    logic              ram_en;
    logic              ram_wr;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    // Status
    logic              busy;

    modport master (
        output req_a, wr_a, addr_a, wdata_a,
        input  gnt_a, rdata_a, rvalid_a,
        output req_b, wr_b, addr_b, wdata_b,
        input  gnt_b, rdata_b, rvalid_b,
        input  ram_en, ram_wr, ram_addr, ram_wdata,
        output ram_rdata,
        input  busy
    );

    modport slave (
        input  req_a, wr_a, addr_a, wdata_a,
        output gnt_a, rdata_a, rvalid_a,
        input  req_b, wr_b, addr_b, wdata_b,
        output gnt_b, rdata_b, rvalid_b,
        output ram_en, ram_wr, ram_addr, ram_wdata,
        input  ram_rdata,
        output busy
    );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port RAM between two requesters.
// One command is in flight at a time; IDLE -> ACCESS (1 cycle) -> IDLE for
// writes, IDLE -> ACCESS -> RESP (1 cycle) -> IDLE for reads, with the read
// data returned with a one-cycle rvalid pulse in the cycle after RESP.
// Every output is a register loaded from the next-cycle values computed by
// the output process, so gnt/ram_* are visible during ACCESS itself.
// Ties are resolved round-robin by default; defining FIXED_PRIORITY_EN makes
// requester A always win ties (B can starve and no last_grant is kept).
// Reset (rst_n) is synchronous, active-low, and wins over everything.
module ram_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    ram_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    state_e state_r;
    state_e next_state_s;

    // Arbitration and selected command
    logic              any_req_s;
    logic              start_s;
    logic              pick_b_s;
    logic              sel_wr_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;

    // Latched command attributes still needed after ACCESS; the address and
    // write data live in the ram_addr/ram_wdata output registers.
    logic              cmd_b_r;
    logic              cmd_wr_r;

    // Next-cycle output values
    logic              gnt_a_s;
    logic              gnt_b_s;
    logic              rvalid_a_s;
    logic              rvalid_b_s;
    logic [DATA_W-1:0] rdata_a_s;
    logic [DATA_W-1:0] rdata_b_s;
    logic              ram_en_s;
    logic              ram_wr_s;
    logic [ADDR_W-1:0] ram_addr_s;
    logic [DATA_W-1:0] ram_wdata_s;
    logic              busy_s;

    // Output registers
    logic              gnt_a_r;
    logic              gnt_b_r;
    logic              rvalid_a_r;
    logic              rvalid_b_r;
    logic [DATA_W-1:0] rdata_a_r;
    logic [DATA_W-1:0] rdata_b_r;
    logic              ram_en_r;
    logic              ram_wr_r;
    logic [ADDR_W-1:0] ram_addr_r;
    logic [DATA_W-1:0] ram_wdata_r;
    logic              busy_r;

`ifdef FIXED_PRIORITY_EN
    // Fixed priority: A wins whenever it requests.
    always_comb begin
        pick_b_s = bus.req_b & ~bus.req_a;
    end
`else
    // 1 = B was granted last, 0 = A was granted last.
    logic last_grant_r;

    // Round-robin history, updated only while a command is on the RAM.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant_r <= 1'b1;
        end else if (state_r == ST_ACCESS) begin
            last_grant_r <= cmd_b_r;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

    // Round-robin: on a tie the requester not granted last wins.
    always_comb begin
        pick_b_s = bus.req_b & (~bus.req_a | ~last_grant_r);
    end
`endif

    // Mux the winning requester's command and detect a new start in IDLE.
    always_comb begin
        any_req_s = bus.req_a | bus.req_b;
        start_s   = (state_r == ST_IDLE) & any_req_s;
        if (pick_b_s) begin
            sel_wr_s    = bus.wr_b;
            sel_addr_s  = bus.addr_b;
            sel_wdata_s = bus.wdata_b;
        end else begin
            sel_wr_s    = bus.wr_a;
            sel_addr_s  = bus.addr_a;
            sel_wdata_s = bus.wdata_a;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    next_state_s = ST_ACCESS;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (cmd_wr_r) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_RESP;
                end
            end
            ST_RESP: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Latch winner identity and direction when a command is accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_b_r  <= 1'b0;
            cmd_wr_r <= 1'b0;
        end else if (start_s) begin
            cmd_b_r  <= pick_b_s;
            cmd_wr_r <= sel_wr_s;
        end else begin
            cmd_b_r  <= cmd_b_r;
            cmd_wr_r <= cmd_wr_r;
        end
    end

    // Output logic: values the output registers take at the next edge.
    always_comb begin
        gnt_a_s     = 1'b0;
        gnt_b_s     = 1'b0;
        rvalid_a_s  = 1'b0;
        rvalid_b_s  = 1'b0;
        rdata_a_s   = rdata_a_r;
        rdata_b_s   = rdata_b_r;
        ram_en_s    = 1'b0;
        ram_wr_s    = 1'b0;
        ram_addr_s  = {ADDR_W{1'b0}};
        ram_wdata_s = {DATA_W{1'b0}};
        busy_s      = (next_state_s != ST_IDLE);
        case (state_r)
            ST_IDLE: begin
                // Entering ACCESS: present the command and grant the winner.
                if (start_s) begin
                    ram_en_s    = 1'b1;
                    ram_wr_s    = sel_wr_s;
                    ram_addr_s  = sel_addr_s;
                    ram_wdata_s = sel_wdata_s;
                    gnt_a_s     = ~pick_b_s;
                    gnt_b_s     = pick_b_s;
                end else begin
                    ram_en_s    = 1'b0;
                end
            end
            ST_ACCESS: begin
                // RAM command drops; read data arrives during RESP.
                ram_en_s = 1'b0;
            end
            ST_RESP: begin
                // Capture RAM data for the winner and flag it next cycle.
                rvalid_a_s = ~cmd_b_r;
                rvalid_b_s = cmd_b_r;
                if (cmd_b_r) begin
                    rdata_b_s = bus.ram_rdata;
                end else begin
                    rdata_a_s = bus.ram_rdata;
                end
            end
            default: begin
                ram_en_s = 1'b0;
            end
        endcase
    end

    // Output registers; reset clears everything and aborts any operation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gnt_a_r     <= 1'b0;
            gnt_b_r     <= 1'b0;
            rvalid_a_r  <= 1'b0;
            rvalid_b_r  <= 1'b0;
            rdata_a_r   <= {DATA_W{1'b0}};
            rdata_b_r   <= {DATA_W{1'b0}};
            ram_en_r    <= 1'b0;
            ram_wr_r    <= 1'b0;
            ram_addr_r  <= {ADDR_W{1'b0}};
            ram_wdata_r <= {DATA_W{1'b0}};
            busy_r      <= 1'b0;
        end else begin
            gnt_a_r     <= gnt_a_s;
            gnt_b_r     <= gnt_b_s;
            rvalid_a_r  <= rvalid_a_s;
            rvalid_b_r  <= rvalid_b_s;
            rdata_a_r   <= rdata_a_s;
            rdata_b_r   <= rdata_b_s;
            ram_en_r    <= ram_en_s;
            ram_wr_r    <= ram_wr_s;
            ram_addr_r  <= ram_addr_s;
            ram_wdata_r <= ram_wdata_s;
            busy_r      <= busy_s;
        end
    end

    assign bus.gnt_a     = gnt_a_r;
    assign bus.gnt_b     = gnt_b_r;
    assign bus.rvalid_a  = rvalid_a_r;
    assign bus.rvalid_b  = rvalid_b_r;
    assign bus.rdata_a   = rdata_a_r;
    assign bus.rdata_b   = rdata_b_r;
    assign bus.ram_en    = ram_en_r;
    assign bus.ram_wr    = ram_wr_r;
    assign bus.ram_addr  = ram_addr_r;
    assign bus.ram_wdata = ram_wdata_r;
    assign bus.busy      = busy_r;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter.
// A transaction-level model predicts, at each sampling edge, which requester
// is served, what appears on the RAM port, and when/what read data returns
// (from a shadow memory). Predictions go into queues; a monitor on the
// falling edge pops and compares whatever the DUT presents.
module tb_ram_arbiter;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst_n;

    ram_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    ram_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit                wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    typedef struct {
        int                cyc;
        bit                is_b;
        bit                wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } gexp_t;

    typedef struct {
        int                cyc;
        bit                is_b;
        logic [DATA_W-1:0] data;
    } rexp_t;

    cmd_t  qa[$];
    cmd_t  qb[$];
    gexp_t gq[$];
    rexp_t rq[$];

    logic [DATA_W-1:0] ram_mem [DEPTH];
    logic [DATA_W-1:0] shadow  [DEPTH];

    int cyc         = 0;
    int next_sample = 0;
    int bs          = 0;
    int be          = -1;
    int rst_cyc     = -1;
    bit last_b      = 1'b1;
    bit started     = 1'b0;

    int checks   = 0;
    int failures = 0;

    bit on_a = 1'b0;
    bit on_b = 1'b0;
    bit ga_s = 1'b0;
    bit gb_s = 1'b0;
    int p_issue = 100;
    bit glitch  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s actual=%0h expected=%0h cyc=%0d", nm, act, exp, cyc);
        end
    endtask

    // Simple synchronous RAM: read data valid the cycle after a read command,
    // random garbage otherwise; contents cleared by reset.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) ram_mem[i] <= '0;
            bus.ram_rdata <= '0;
        end else begin
            if (bus.ram_en && bus.ram_wr) ram_mem[bus.ram_addr] <= bus.ram_wdata;
            if (bus.ram_en && !bus.ram_wr) bus.ram_rdata <= ram_mem[bus.ram_addr];
            else bus.ram_rdata <= DATA_W'($urandom);
        end
    end

    // Reference model: one server, sampled when free; writes occupy it for
    // 2 cycles, reads for 3; read data returns 2 cycles after the grant.
    initial begin
        bit pb;
        gexp_t e;
        rexp_t r;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                started = 1'b1;
                gq.delete();
                rq.delete();
                for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
                next_sample = cyc + 1;
                last_b = 1'b1;
                bs = 0;
                be = -1;
                rst_cyc = cyc;
            end else if (cyc >= next_sample && (bus.req_a || bus.req_b)) begin
`ifdef FIXED_PRIORITY_EN
                pb = !bus.req_a;
`else
                pb = bus.req_b && (!bus.req_a || !last_b);
`endif
                e.cyc   = cyc;
                e.is_b  = pb;
                e.wr    = pb ? bus.wr_b : bus.wr_a;
                e.addr  = pb ? bus.addr_b : bus.addr_a;
                e.wdata = pb ? bus.wdata_b : bus.wdata_a;
                gq.push_back(e);
                if (e.wr) begin
                    shadow[e.addr] = e.wdata;
                    next_sample = cyc + 2;
                    be = cyc;
                end else begin
                    r.cyc  = cyc + 2;
                    r.is_b = pb;
                    r.data = shadow[e.addr];
                    rq.push_back(r);
                    next_sample = cyc + 3;
                    be = cyc + 1;
                end
                bs = cyc;
                last_b = pb;
            end
        end
    end

    // Monitor: compare DUT outputs against the predictions for this cycle.
    initial begin
        gexp_t e;
        rexp_t r;
        bit hg;
        bit hr;
        logic [DATA_W-1:0] hold_a;
        logic [DATA_W-1:0] hold_b;
        hold_a = '0;
        hold_b = '0;
        forever begin
            @(negedge clk);
            if (started) begin
                if (rst_cyc == cyc) begin
                    hold_a = '0;
                    hold_b = '0;
                end
                hg = 1'b0;
                if (gq.size() > 0 && gq[0].cyc == cyc) begin
                    e = gq.pop_front();
                    hg = 1'b1;
                end
                chk("gnt_a", 32'(bus.gnt_a), 32'(hg && !e.is_b));
                chk("gnt_b", 32'(bus.gnt_b), 32'(hg && e.is_b));
                chk("ram_en", 32'(bus.ram_en), 32'(hg));
                chk("ram_wr", 32'(bus.ram_wr), hg ? 32'(e.wr) : 32'd0);
                chk("ram_addr", 32'(bus.ram_addr), hg ? 32'(e.addr) : 32'd0);
                chk("ram_wdata", 32'(bus.ram_wdata), hg ? 32'(e.wdata) : 32'd0);
                chk("busy", 32'(bus.busy), 32'(cyc >= bs && cyc <= be));
                hr = 1'b0;
                if (rq.size() > 0 && rq[0].cyc == cyc) begin
                    r = rq.pop_front();
                    hr = 1'b1;
                    if (r.is_b) hold_b = r.data;
                    else hold_a = r.data;
                end
                chk("rvalid_a", 32'(bus.rvalid_a), 32'(hr && !r.is_b));
                chk("rvalid_b", 32'(bus.rvalid_b), 32'(hr && r.is_b));
                chk("rdata_a", 32'(bus.rdata_a), 32'(hold_a));
                chk("rdata_b", 32'(bus.rdata_b), 32'(hold_b));
            end
        end
    end

    // One clock of requester behaviour: drop req at the edge that saw gnt,
    // optionally present the next queued command, keep it stable otherwise.
    task automatic step();
        cmd_t c;
        @(negedge clk);
        ga_s = bus.gnt_a;
        gb_s = bus.gnt_b;
        @(posedge clk);
        #1;
        if (on_a && ga_s) on_a = 1'b0;
        if (on_b && gb_s) on_b = 1'b0;
        if (!on_a) begin
            if (qa.size() > 0 && $urandom_range(0, 99) < p_issue) begin
                c = qa.pop_front();
                bus.wr_a = c.wr; bus.addr_a = c.addr; bus.wdata_a = c.wdata;
                on_a = 1'b1;
            end else begin
                bus.wr_a = 1'($urandom); bus.addr_a = ADDR_W'($urandom); bus.wdata_a = DATA_W'($urandom);
            end
        end
        if (!on_b) begin
            if (qb.size() > 0 && $urandom_range(0, 99) < p_issue) begin
                c = qb.pop_front();
                bus.wr_b = c.wr; bus.addr_b = c.addr; bus.wdata_b = c.wdata;
                on_b = 1'b1;
            end else begin
                bus.wr_b = 1'($urandom); bus.addr_b = ADDR_W'($urandom); bus.wdata_b = DATA_W'($urandom);
            end
        end
        bus.req_a = on_a;
        bus.req_b = on_b;
        if (glitch && !on_a) begin
            bus.req_a = 1'b1;
            #2;
            bus.req_a = 1'b0;
        end
    endtask

    function automatic cmd_t rnd_cmd(input bit wr);
        cmd_t c;
        c.wr = wr;
        c.addr = ADDR_W'($urandom);
        c.wdata = DATA_W'($urandom);
        return c;
    endfunction

    initial begin
        cmd_t c;
        bit found;
        int n;
        rst_n = 1'b0;
        bus.req_a = 1'b0; bus.wr_a = 1'b0; bus.addr_a = '0; bus.wdata_a = '0;
        bus.req_b = 1'b0; bus.wr_b = 1'b0; bus.addr_b = '0; bus.wdata_b = '0;

        repeat (3) step();
        rst_n = 1'b1;

        // Quiet bus: nothing moves.
        repeat (20) step();

        // Write A 0x1 <- 0xFF, then read it back.
        c.wr = 1'b1; c.addr = 4'h1; c.wdata = 8'hFF; qa.push_back(c);
        repeat (6) step();
        c.wr = 1'b0; c.addr = 4'h1; c.wdata = 8'h00; qa.push_back(c);
        repeat (6) step();

        // Continuous tie of writes straight after reset.
        rst_n = 1'b0; step(); rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            qa.push_back(rnd_cmd(1'b1));
            qb.push_back(rnd_cmd(1'b1));
        end
        repeat (16) step();

        // Read B 0x3, reset during RESP, then a tie.
        c.wr = 1'b0; c.addr = 4'h3; c.wdata = 8'h00; qb.push_back(c);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (gb_s) found = 1'b1;
        end
        chk("rst_resp_gnt_b_seen", 32'(found), 32'd1);
        rst_n = 1'b0; step(); rst_n = 1'b1;
        qa.push_back(rnd_cmd(1'b1));
        qb.push_back(rnd_cmd(1'b1));
        repeat (8) step();

        // B raises during A's ACCESS.
        qa.push_back(rnd_cmd(1'b1));
        step();
        qb.push_back(rnd_cmd(1'b0));
        repeat (8) step();

        // Short req pulses that never meet a clock edge.
        glitch = 1'b1;
        repeat (6) step();
        glitch = 1'b0;

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 1) == 0) qa.push_back(rnd_cmd(1'($urandom)));
            else qb.push_back(rnd_cmd(1'($urandom)));
        end
        n = 0;
        while (n < 4000 && (qa.size() > 0 || qb.size() > 0 || on_a || on_b)) begin
            p_issue = $urandom_range(20, 100);
            rst_n = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            step();
            n++;
        end
        rst_n = 1'b1;
        p_issue = 100;
        chk("traffic_drained", 32'(qa.size() + qb.size() + int'(on_a) + int'(on_b)), 32'd0);
        repeat (6) step();
        chk("gnt_queue_empty", 32'(gq.size()), 32'd0);
        chk("rvalid_queue_empty", 32'(rq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
